cpu7_csr_exc: RTL and testbench
===============================

CPU7_CSR_EXC -- requirements
Module: cpu7_csr_exc

Interface
REQ-001 SHALL provide parameter GRLEN, default 32, datapath and CSR width.
REQ-002 SHALL provide parameter SAVE_NUM, default 4, number of SAVE scratch CSRs (1..16) at 0x30+i.
REQ-003 SHALL provide parameter TIMER_W, default 32, timer counter width (8..GRLEN).
REQ-004 SHALL provide parameter NUM_HWI, default 8, hardware interrupt lines (1..8), mapped to ESTAT.IS[2+i].
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports are clk and reset.
REQ-006 SHALL have ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- csr_raddr  in  14  read address
- csr_rdata  out  GRLEN  combinational read data
- csr_waddr  in  14  write address
- csr_wdata  in  GRLEN  write data
- csr_wen  in  1  write strobe
- exc_valid  in  1  exception commit this cycle
- exc_ecode  in  6  exception code
- exc_pc  in  GRLEN  faulting PC
- exc_badv_vld  in  1  exc_badv valid
- exc_badv  in  GRLEN  faulting address
- ertn_valid  in  1  ERTN commit this cycle
- hwi  in  NUM_HWI  level interrupt inputs
- csr_eentry  out  GRLEN  EENTRY
- csr_era  out  GRLEN  ERA
- int_req  out  1  interrupt request to pipeline

Function
REQ-007 SHALL implement CSRs: CRMD 0x0 {IE[2],PLV[1:0]}, PRMD 0x1 {PIE[2],PPLV[1:0]}, ECFG 0x4 LIE[11:0], ESTAT 0x5 {Ecode[21:16],IS[11:0]}, ERA 0x6, BADV 0x7, EENTRY 0xc, SAVEi 0x30+i, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
REQ-008 Unimplemented addresses and unimplemented bits SHALL read 0; writes to them SHALL be ignored.
REQ-009 Reads SHALL be combinational; a write SHALL be visible on csr_rdata the cycle after csr_wen.
REQ-010 On exc_valid: PRMD<=CRMD{IE,PLV}; CRMD.IE,PLV<=0; ERA<=exc_pc; ESTAT.Ecode<=exc_ecode; BADV<=exc_badv only if exc_badv_vld.
REQ-011 On ertn_valid (exc_valid low): CRMD.IE<=PRMD.PIE, CRMD.PLV<=PRMD.PPLV.
REQ-012 Same-cycle priority per register: exc_valid > ertn_valid > csr_wen; lower-priority update dropped.
REQ-013 ESTAT.IS[1:0] software-writable; IS[2+NUM_HWI-1:2] SHALL be registered copies of hwi, sampled every cycle, read-only; IS[10] tied 0; IS[11] is TI.
REQ-014 ECFG.LIE bit 10 SHALL read 0; other bits read/write.
REQ-015 int_req SHALL be registered: CRMD.IE & |(ESTAT.IS & ECFG.LIE), one cycle after cause.
REQ-016 TCFG {InitVal[TIMER_W-1:2],Periodic[1],En[0]}; write SHALL load TVAL<={InitVal,2'b00} next cycle.
REQ-017 While En and TVAL!=0 TVAL SHALL decrement by 1 per cycle.
REQ-018 When En and TVAL==0: set TI; Periodic=1 reloads {InitVal,2'b00}; Periodic=0 clears En, TVAL holds 0.
REQ-019 TVAL read-only, zero-extended to GRLEN; TICLR reads 0; TICLR write with wdata[0]=1 clears TI.
REQ-020 TI set and TICLR clear in same cycle: set SHALL win.
REQ-021 TVAL==0 with En set by a TCFG write of InitVal=0: TI sets the cycle after the write.

Reset
REQ-022 Reset SHALL zero all registers, including int_req, TI, TVAL, TCFG; TID resets to 0.
REQ-023 Reset SHALL override exc_valid, ertn_valid, csr_wen and timer activity in the same cycle.
REQ-024 Reset mid-countdown SHALL stop the timer; no TI after reset until TCFG is rewritten.

Configuration
REQ-025 Macro CPU7_CSR_TIMER_EN defined: TID/TCFG/TVAL/TICLR and TI as above.
REQ-026 Macro undefined: those addresses read 0, writes ignored, ESTAT.IS[11] constant 0, no timer flops.

Structure
REQ-027 CSR addresses, field bit positions, and ecode values SHALL live in common.vh, shared with decode.
REQ-028 The timer (TCFG/TVAL/TI/TICLR) SHALL be sub-module cpu7_csr_timer, instantiated only under CPU7_CSR_TIMER_EN.

Verification
REQ-029 CRMD=0x7, exc_valid with ecode 0x9, exc_pc 0x1c000100, badv_vld with badv 0x1234 -> CRMD 0x0, PRMD 0x7, ERA 0x1c000100, ESTAT[21:16]=0x9, BADV 0x1234.
REQ-030 PRMD=0x5 then ertn_valid -> CRMD 0x5; concurrent exc_valid+ertn_valid+CRMD write 0x3 -> exception result only.
REQ-031 TCFG=0x0000000b (InitVal 2, periodic, en) -> TVAL 8,7..0, TI set, TVAL reloads 8; TICLR=1 at TVAL==0 -> TI stays 1.
REQ-032 TCFG=0x9 (one-shot) -> TI after 9 cycles, En cleared, TVAL holds 0.
REQ-033 CRMD.IE=1, LIE=0x004, hwi[0]=1 -> int_req high two cycles after hwi; LIE=0 -> low next cycle.
REQ-034 SAVE_NUM=2: write 0x30,0x31,0x32 -> first two read back, 0x32 reads 0; build without CPU7_CSR_TIMER_EN -> TCFG reads 0.

Source files
------------

// File: rtl/cpu7_csr_exc_pkg.sv
// Shared CSR map for cpu7: addresses, field bit positions and exception codes,
// imported by the CSR block and by instruction decode.
package cpu7_csr_exc_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int unsigned CRMD_IE_BIT     = 2;
  localparam int unsigned ESTAT_ECODE_LSB = 16;
  localparam int unsigned ESTAT_IS_W      = 12;
  localparam int unsigned IS_HWI_LSB      = 2;
  localparam int unsigned IS_TI_BIT       = 11;
  localparam int unsigned LIE_RSVD_BIT    = 10;
  localparam int unsigned TCFG_EN_BIT     = 0;
  localparam int unsigned TCFG_PERIOD_BIT = 1;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;

endpackage

// File: rtl/cpu7_csr_exc_timer.sv
// Constant timer: TCFG/TVAL countdown with periodic reload or one-shot stop,
// and the TI pending flag. Only built when CPU7_CSR_TIMER_EN is defined.
module cpu7_csr_timer
  import cpu7_csr_exc_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_wen,
  input  logic [TIMER_W-1:0] tcfg_wdata,
  input  logic               ti_clr,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               ti
);

  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic               ti_q, ti_d;
  logic               fire;

  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    fire   = 1'b0;
    if (tcfg_wen) begin
      tcfg_d = tcfg_wdata;
      tval_d = {tcfg_wdata[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[TCFG_EN_BIT]) begin
      if (tval_q != '0) begin
        tval_d = tval_q - 1'b1;
      end else begin
        fire = 1'b1;
        if (tcfg_q[TCFG_PERIOD_BIT]) tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
        else                         tcfg_d[TCFG_EN_BIT] = 1'b0;
      end
    end
    // set is applied last so it wins over a same-cycle clear
    ti_d = ti_q;
    if (ti_clr) ti_d = 1'b0;
    if (fire)   ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end

  assign tcfg = tcfg_q;
  assign tval = tval_q;
  assign ti   = ti_q;

endmodule

// File: rtl/cpu7_csr_exc.sv
// cpu7 exception/interrupt CSR file (CRMD..EENTRY, SAVE, optional timer).
// Timer CSRs and ESTAT.TI exist only when CPU7_CSR_TIMER_EN is defined.
module cpu7_csr_exc
  import cpu7_csr_exc_pkg::*;
#(
  parameter int unsigned GRLEN    = 32,
  parameter int unsigned SAVE_NUM = 4,
  parameter int unsigned TIMER_W  = 32,
  parameter int unsigned NUM_HWI  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [13:0]        csr_raddr,
  output logic [GRLEN-1:0]   csr_rdata,
  input  logic [13:0]        csr_waddr,
  input  logic [GRLEN-1:0]   csr_wdata,
  input  logic               csr_wen,
  input  logic               exc_valid,
  input  logic [5:0]         exc_ecode,
  input  logic [GRLEN-1:0]   exc_pc,
  input  logic               exc_badv_vld,
  input  logic [GRLEN-1:0]   exc_badv,
  input  logic               ertn_valid,
  input  logic [NUM_HWI-1:0] hwi,
  output logic [GRLEN-1:0]   csr_eentry,
  output logic [GRLEN-1:0]   csr_era,
  output logic               int_req
);

  logic                  crmd_ie_q, crmd_ie_d, prmd_pie_q, prmd_pie_d;
  logic [1:0]            crmd_plv_q, crmd_plv_d, prmd_pplv_q, prmd_pplv_d;
  logic [11:0]           lie_q, lie_d;
  logic [1:0]            is_sw_q, is_sw_d;
  logic [5:0]            ecode_q, ecode_d;
  logic [NUM_HWI-1:0]    hwi_q, hwi_d;
  logic [GRLEN-1:0]      era_q, era_d, badv_q, badv_d, eentry_q, eentry_d;
  logic [GRLEN-1:0]      save_q [SAVE_NUM];
  logic [GRLEN-1:0]      save_d [SAVE_NUM];
  logic                  int_req_q, int_req_d;
  logic [ESTAT_IS_W-1:0] estat_is;
  logic                  timer_ti;
  logic                  wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry;

  assign wr_crmd   = csr_wen && (csr_waddr == CSR_CRMD);
  assign wr_prmd   = csr_wen && (csr_waddr == CSR_PRMD);
  assign wr_ecfg   = csr_wen && (csr_waddr == CSR_ECFG);
  assign wr_estat  = csr_wen && (csr_waddr == CSR_ESTAT);
  assign wr_era    = csr_wen && (csr_waddr == CSR_ERA);
  assign wr_badv   = csr_wen && (csr_waddr == CSR_BADV);
  assign wr_eentry = csr_wen && (csr_waddr == CSR_EENTRY);

`ifdef CPU7_CSR_TIMER_EN
  logic [TIMER_W-1:0] tcfg, tval;
  logic [GRLEN-1:0]   tid_q, tid_d;

  assign tid_d = (csr_wen && (csr_waddr == CSR_TID)) ? csr_wdata : tid_q;

  always_ff @(posedge clk) begin
    if (reset) tid_q <= '0;
    else       tid_q <= tid_d;
  end

  cpu7_csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tcfg_wen   (csr_wen && (csr_waddr == CSR_TCFG)),
    .tcfg_wdata (csr_wdata[TIMER_W-1:0]),
    .ti_clr     (csr_wen && (csr_waddr == CSR_TICLR) && csr_wdata[0]),
    .tcfg       (tcfg),
    .tval       (tval),
    .ti         (timer_ti)
  );
`else
  assign timer_ti = 1'b0;
`endif

  always_comb begin
    estat_is                         = '0;
    estat_is[1:0]                    = is_sw_q;
    estat_is[IS_HWI_LSB +: NUM_HWI]  = hwi_q;
    estat_is[IS_TI_BIT]              = timer_ti;
  end

  // exception commit owns every register it touches; ERTN only owns CRMD
  always_comb begin
    crmd_ie_d   = crmd_ie_q;
    crmd_plv_d  = crmd_plv_q;
    prmd_pie_d  = prmd_pie_q;
    prmd_pplv_d = prmd_pplv_q;
    is_sw_d     = is_sw_q;
    ecode_d     = ecode_q;
    era_d       = era_q;
    badv_d      = badv_q;
    if (exc_valid) begin
      prmd_pie_d  = crmd_ie_q;
      prmd_pplv_d = crmd_plv_q;
      crmd_ie_d   = 1'b0;
      crmd_plv_d  = 2'b00;
      era_d       = exc_pc;
      ecode_d     = exc_ecode;
      if (exc_badv_vld) badv_d = exc_badv;
    end else begin
      if (ertn_valid) begin
        crmd_ie_d  = prmd_pie_q;
        crmd_plv_d = prmd_pplv_q;
      end else if (wr_crmd) begin
        crmd_ie_d  = csr_wdata[CRMD_IE_BIT];
        crmd_plv_d = csr_wdata[1:0];
      end
      if (wr_prmd) begin
        prmd_pie_d  = csr_wdata[CRMD_IE_BIT];
        prmd_pplv_d = csr_wdata[1:0];
      end
      if (wr_estat) is_sw_d = csr_wdata[1:0];
      if (wr_era)   era_d   = csr_wdata;
      if (wr_badv)  badv_d  = csr_wdata;
    end
    lie_d = lie_q;
    if (wr_ecfg) begin
      lie_d               = csr_wdata[11:0];
      lie_d[LIE_RSVD_BIT] = 1'b0;
    end
    eentry_d = wr_eentry ? csr_wdata : eentry_q;
    save_d   = save_q;
    for (int unsigned i = 0; i < SAVE_NUM; i++) begin
      if (csr_wen && (csr_waddr == 14'(CSR_SAVE0 + i))) save_d[i] = csr_wdata;
    end
    hwi_d     = hwi;
    int_req_d = crmd_ie_q && ((estat_is & lie_q) != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_ie_q   <= 1'b0;
      crmd_plv_q  <= '0;
      prmd_pie_q  <= 1'b0;
      prmd_pplv_q <= '0;
      lie_q       <= '0;
      is_sw_q     <= '0;
      ecode_q     <= '0;
      hwi_q       <= '0;
      era_q       <= '0;
      badv_q      <= '0;
      eentry_q    <= '0;
      save_q      <= '{default: '0};
      int_req_q   <= 1'b0;
    end else begin
      crmd_ie_q   <= crmd_ie_d;
      crmd_plv_q  <= crmd_plv_d;
      prmd_pie_q  <= prmd_pie_d;
      prmd_pplv_q <= prmd_pplv_d;
      lie_q       <= lie_d;
      is_sw_q     <= is_sw_d;
      ecode_q     <= ecode_d;
      hwi_q       <= hwi_d;
      era_q       <= era_d;
      badv_q      <= badv_d;
      eentry_q    <= eentry_d;
      save_q      <= save_d;
      int_req_q   <= int_req_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_CRMD:   csr_rdata[2:0] = {crmd_ie_q, crmd_plv_q};
      CSR_PRMD:   csr_rdata[2:0] = {prmd_pie_q, prmd_pplv_q};
      CSR_ECFG:   csr_rdata[11:0] = lie_q;
      CSR_ESTAT: begin
        csr_rdata[ESTAT_ECODE_LSB +: 6] = ecode_q;
        csr_rdata[ESTAT_IS_W-1:0]       = estat_is;
      end
      CSR_ERA:    csr_rdata = era_q;
      CSR_BADV:   csr_rdata = badv_q;
      CSR_EENTRY: csr_rdata = eentry_q;
`ifdef CPU7_CSR_TIMER_EN
      CSR_TID:    csr_rdata = tid_q;
      CSR_TCFG:   csr_rdata[TIMER_W-1:0] = tcfg;
      CSR_TVAL:   csr_rdata[TIMER_W-1:0] = tval;
`endif
      default:    ;
    endcase
    for (int unsigned i = 0; i < SAVE_NUM; i++) begin
      if (csr_raddr == 14'(CSR_SAVE0 + i)) csr_rdata = save_q[i];
    end
  end

  assign csr_eentry = eentry_q;
  assign csr_era    = era_q;
  assign int_req    = int_req_q;

endmodule

// File: tb/tb_cpu7_csr_exc.sv
// Self-checking bench for cpu7_csr_exc (SAVE_NUM=2): directed scenarios, then
// random traffic against a register-level reference model.
module tb_cpu7_csr_exc;

  logic        clk;
  logic        reset;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_wen, exc_valid, exc_badv_vld, ertn_valid;
  logic [5:0]  exc_ecode;
  logic [31:0] exc_pc, exc_badv, csr_eentry, csr_era;
  logic [7:0]  hwi;
  logic        int_req;

  int n_checks = 0;
  int n_fail   = 0;

  cpu7_csr_exc #(.GRLEN(32), .SAVE_NUM(2), .TIMER_W(32), .NUM_HWI(8)) dut (
    .clk(clk), .reset(reset), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .exc_valid(exc_valid), .exc_ecode(exc_ecode), .exc_pc(exc_pc),
    .exc_badv_vld(exc_badv_vld), .exc_badv(exc_badv), .ertn_valid(ertn_valid),
    .hwi(hwi), .csr_eentry(csr_eentry), .csr_era(csr_era), .int_req(int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: architectural register contents
  logic [2:0]  m_crmd, m_prmd;
  logic [11:0] m_lie;
  logic [1:0]  m_sw;
  logic [5:0]  m_ecode;
  logic [7:0]  m_hwi;
  logic [31:0] m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
  logic [31:0] m_save [2];
  logic        m_ti, m_int;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [13:0] a);
    case (a)
      14'h000: return {29'd0, m_crmd};
      14'h001: return {29'd0, m_prmd};
      14'h004: return {20'd0, m_lie};
      14'h005: return {10'd0, m_ecode, 4'd0, m_ti, 1'b0, m_hwi, m_sw};
      14'h006: return m_era;
      14'h007: return m_badv;
      14'h00c: return m_eentry;
      14'h030: return m_save[0];
      14'h031: return m_save[1];
`ifdef CPU7_CSR_TIMER_EN
      14'h040: return m_tid;
      14'h041: return m_tcfg;
      14'h042: return m_tval;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [11:0] is_v;
    logic        fired, wr;
    logic [13:0] a;
    logic [31:0] d;
    wr = csr_wen; a = csr_waddr; d = csr_wdata;
    if (reset) begin
      m_crmd = 0; m_prmd = 0; m_lie = 0; m_sw = 0; m_ecode = 0; m_hwi = 0;
      m_era = 0; m_badv = 0; m_eentry = 0; m_tid = 0; m_tcfg = 0; m_tval = 0;
      m_save[0] = 0; m_save[1] = 0; m_ti = 0; m_int = 0;
    end else begin
      is_v  = {m_ti, 1'b0, m_hwi, m_sw};
      m_int = m_crmd[2] && ((is_v & m_lie) != 0);
      m_hwi = hwi;
      if (exc_valid) begin
        m_prmd = m_crmd; m_crmd = 0; m_era = exc_pc; m_ecode = exc_ecode;
        if (exc_badv_vld) m_badv = exc_badv;
      end else begin
        if (ertn_valid)            m_crmd = m_prmd;
        else if (wr && a == 14'h0) m_crmd = d[2:0];
        if (wr && a == 14'h1) m_prmd = d[2:0];
        if (wr && a == 14'h5) m_sw   = d[1:0];
        if (wr && a == 14'h6) m_era  = d;
        if (wr && a == 14'h7) m_badv = d;
      end
      if (wr && a == 14'h4)  m_lie     = d[11:0] & 12'hbff;
      if (wr && a == 14'hc)  m_eentry  = d;
      if (wr && a == 14'h30) m_save[0] = d;
      if (wr && a == 14'h31) m_save[1] = d;
`ifdef CPU7_CSR_TIMER_EN
      if (wr && a == 14'h40) m_tid = d;
      fired = 1'b0;
      if (wr && a == 14'h41) begin
        m_tcfg = d; m_tval = d & ~32'd3;
      end else if (m_tcfg[0]) begin
        if (m_tval != 0) m_tval = m_tval - 1;
        else begin
          fired = 1'b1;
          if (m_tcfg[1]) m_tval = m_tcfg & ~32'd3;
          else           m_tcfg[0] = 1'b0;
        end
      end
      if (fired) m_ti = 1'b1;
      else if (wr && a == 14'h44 && d[0]) m_ti = 1'b0;
`endif
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_wen = 0; exc_valid = 0; ertn_valid = 0; exc_badv_vld = 0; reset = 0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_wen = 1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_wen = 0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] v);
    csr_raddr = a;
    #1;
    v = csr_rdata;
  endtask

  task automatic rd_check(input string tag, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  logic [31:0] v;
  logic [13:0] addrs [16] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hc, 14'h30,
                              14'h31, 14'h32, 14'h40, 14'h41, 14'h42, 14'h44, 14'h2, 14'h50};

  initial begin
    idle();
    csr_raddr = 0; csr_waddr = 0; csr_wdata = 0; exc_ecode = 0; exc_pc = 0;
    exc_badv = 0; hwi = 0;
    reset = 1;
    tick(); tick();
    // reset beats a simultaneous write and exception
    csr_wen = 1; csr_waddr = 14'h0; csr_wdata = 32'h7; exc_valid = 1; exc_pc = 32'h55;
    tick();
    idle();
    rd_check("rst_crmd", 14'h0, 0);
    rd_check("rst_prmd", 14'h1, 0);
    rd_check("rst_estat", 14'h5, 0);
    check("rst_era", csr_era, 0);
    check("rst_int", {31'd0, int_req}, 0);
    rd_check("rst_tcfg", 14'h41, 0);

    wr(14'h0, 32'h7);
    exc_valid = 1; exc_ecode = 6'h9; exc_pc = 32'h1c000100;
    exc_badv_vld = 1; exc_badv = 32'h1234;
    tick();
    idle();
    rd_check("exc_crmd", 14'h0, 32'h0);
    rd_check("exc_prmd", 14'h1, 32'h7);
    check("exc_era", csr_era, 32'h1c000100);
    rd(14'h5, v);
    check("exc_ecode", {26'd0, v[21:16]}, 32'h9);
    rd_check("exc_badv", 14'h7, 32'h1234);
    tick();

    wr(14'h1, 32'h5);
    ertn_valid = 1;
    tick();
    idle();
    rd_check("ertn_crmd", 14'h0, 32'h5);
    exc_valid = 1; ertn_valid = 1; exc_ecode = 6'hb; exc_pc = 32'h1c000200;
    csr_wen = 1; csr_waddr = 14'h0; csr_wdata = 32'h3;
    tick();
    idle();
    rd_check("prio_crmd", 14'h0, 32'h0);
    rd_check("prio_prmd", 14'h1, 32'h5);
    rd_check("prio_era", 14'h6, 32'h1c000200);
    rd_check("prio_badv", 14'h7, 32'h1234);

    wr(14'h30, 32'hdeadbeef);
    wr(14'h31, 32'h01234567);
    wr(14'h32, 32'hcafef00d);
    rd_check("save0", 14'h30, 32'hdeadbeef);
    rd_check("save1", 14'h31, 32'h01234567);
    rd_check("save2_absent", 14'h32, 32'h0);

    wr(14'h0, 32'h4);
    wr(14'h4, 32'h004);
    hwi = 8'h01;
    tick();
    check("int_lat1", {31'd0, int_req}, 0);
    tick();
    check("int_lat2", {31'd0, int_req}, 1);
    wr(14'h4, 32'h0);
    tick();
    check("int_lie_off", {31'd0, int_req}, 0);
    hwi = 8'h00;
    tick();

`ifdef CPU7_CSR_TIMER_EN
    wr(14'h41, 32'hb);
    rd_check("per_tval_8", 14'h42, 32'd8);
    for (int k = 7; k >= 0; k--) begin
      tick();
      rd_check("per_tval", 14'h42, k);
    end
    rd(14'h5, v);
    check("per_ti_before", {31'd0, v[11]}, 0);
    wr(14'h44, 32'h1);
    rd(14'h5, v);
    check("per_ti_set_wins", {31'd0, v[11]}, 1);
    rd_check("per_reload", 14'h42, 32'd8);
    wr(14'h44, 32'h1);
    rd(14'h5, v);
    check("per_ticlr", {31'd0, v[11]}, 0);

    wr(14'h41, 32'h9);
    for (int k = 0; k < 8; k++) tick();
    rd(14'h5, v);
    check("os_ti_early", {31'd0, v[11]}, 0);
    tick();
    rd(14'h5, v);
    check("os_ti", {31'd0, v[11]}, 1);
    rd_check("os_en_clr", 14'h41, 32'h8);
    tick();
    rd_check("os_tval_hold", 14'h42, 32'h0);

    wr(14'h44, 32'h1);
    wr(14'h41, 32'h1);
    rd(14'h5, v);
    check("z_ti_wr", {31'd0, v[11]}, 0);
    tick();
    rd(14'h5, v);
    check("z_ti_next", {31'd0, v[11]}, 1);

    wr(14'h44, 32'h1);
    wr(14'h41, 32'hb);
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 12; k++) tick();
    rd(14'h5, v);
    check("rst_stop_ti", {31'd0, v[11]}, 0);
    rd_check("rst_stop_tval", 14'h42, 32'h0);
`else
    wr(14'h41, 32'hb);
    tick();
    rd_check("notimer_tcfg", 14'h41, 32'h0);
    rd_check("notimer_tval", 14'h42, 32'h0);
`endif

    for (int n = 0; n < 400; n++) begin
      csr_wen    = ($urandom_range(0, 1) == 1);
      csr_waddr  = addrs[$urandom_range(0, 15)];
      csr_wdata  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
      exc_valid  = !csr_wen && ($urandom_range(0, 7) == 0);
      ertn_valid = ($urandom_range(0, 7) == 0);
      exc_ecode  = 6'($urandom);
      exc_pc     = $urandom;
      exc_badv_vld = ($urandom_range(0, 1) == 1);
      exc_badv   = $urandom;
      hwi        = 8'($urandom);
      reset      = ($urandom_range(0, 49) == 0);
      tick();
      idle();
      csr_raddr = addrs[$urandom_range(0, 15)];
      #1;
      check($sformatf("rnd_rd_%0h", csr_raddr), csr_rdata, m_read(csr_raddr));
      check("rnd_int", {31'd0, int_req}, {31'd0, m_int});
      check("rnd_era", csr_era, m_era);
      check("rnd_eentry", csr_eentry, m_eentry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
